// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS multicycle control path and ALU control decoder.
package mips_pkg;

  localparam int unsigned OP_W    = 6;
  localparam int unsigned ALUOP_W = 2;
  localparam int unsigned STATE_W = 4;
  localparam int unsigned SEL_W   = 2;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;

  localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
  localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
  localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [ALUOP_W-1:0] ALUOP_ADDI  = 2'b11;

  localparam logic [SEL_W-1:0] SRCB_REG    = 2'b00;
  localparam logic [SEL_W-1:0] SRCB_FOUR   = 2'b01;
  localparam logic [SEL_W-1:0] SRCB_IMM    = 2'b10;
  localparam logic [SEL_W-1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [SEL_W-1:0] PCSRC_ALU    = 2'b00;
  localparam logic [SEL_W-1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [SEL_W-1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE          = 4'd0,
    S_FETCH         = 4'd1,
    S_DECODE        = 4'd2,
    S_MEM_ADDR      = 4'd3,
    S_MEM_READ      = 4'd4,
    S_MEM_WB        = 4'd5,
    S_MEM_WRITE     = 4'd6,
    S_EXECUTE       = 4'd7,
    S_R_COMPLETE    = 4'd8,
    S_BRANCH        = 4'd9,
    S_ADDI_EXEC     = 4'd10,
    S_ADDI_COMPLETE = 4'd11,
    S_JUMP          = 4'd12
  } state_t;

  typedef struct packed {
    logic [ALUOP_W-1:0] alu_op;
    logic               alu_src_a;
    logic [SEL_W-1:0]   alu_src_b;
    logic [SEL_W-1:0]   pc_source;
    logic               pc_write;
    logic               pc_write_cond;
    logic               i_or_d;
    logic               mem_read;
    logic               mem_write;
    logic               mem_to_reg;
    logic               ir_write;
    logic               reg_write;
    logic               reg_dst;
    logic               illegal_op;
  } ctrl_t;

  function automatic logic op_is_legal(input logic [OP_W-1:0] op);
    return op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
  endfunction

endpackage

// File: rtl/mips_multicycle_control_if.sv
// Control bus between the multicycle FSM (master) and the datapath (slave).
interface mips_multicycle_control_if;
  import mips_pkg::*;

  logic [OP_W-1:0]    Op;
  logic               Mem_Ready;
  logic [ALUOP_W-1:0] ALU_Op;
  logic               ALUSrcA;
  logic [SEL_W-1:0]   ALUSrcB;
  logic [SEL_W-1:0]   PCSource;
  logic               PCWrite;
  logic               PCWriteCond;
  logic               IorD;
  logic               MemRead;
  logic               MemWrite;
  logic               MemtoReg;
  logic               IRWrite;
  logic               RegWrite;
  logic               RegDst;
  logic               Illegal_Op;
  logic [STATE_W-1:0] State;

  modport master (
    input  Op, Mem_Ready,
    output ALU_Op, ALUSrcA, ALUSrcB, PCSource, PCWrite, PCWriteCond, IorD,
           MemRead, MemWrite, MemtoReg, IRWrite, RegWrite, RegDst, Illegal_Op, State
  );

  modport slave (
    output Op, Mem_Ready,
    input  ALU_Op, ALUSrcA, ALUSrcB, PCSource, PCWrite, PCWriteCond, IorD,
           MemRead, MemWrite, MemtoReg, IRWrite, RegWrite, RegDst, Illegal_Op, State
  );

endinterface

// File: rtl/mips_ctrl_decode.sv
// Combinational map from (state, opcode, memory ready) to every datapath control.
module mips_ctrl_decode
  import mips_pkg::*;
(
  input  state_t          state,
  input  logic [OP_W-1:0] op,
  input  logic            mem_ready,
  output ctrl_t           ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        // IR and PC only advance on the cycle the fetch completes
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b  = SRCB_IMM_SH;
        ctrl.illegal_op = ~op_is_legal(op);
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      S_EXECUTE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_R_COMPLETE: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
      S_ADDI_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADDI;
      end
      S_ADDI_COMPLETE: begin
        ctrl.reg_write = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle main control FSM: state register and next-state logic; outputs decoded from state.
module mips_multicycle_control
  import mips_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  mips_multicycle_control_if.master  bus
);

  state_t state_q;
  state_t state_d;
  ctrl_t  ctrl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      state_d = S_FETCH;
      S_FETCH:     state_d = bus.Mem_Ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.Op)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDI_EXEC;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEM_ADDR:      state_d = (bus.Op == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:      state_d = bus.Mem_Ready ? S_MEM_WB : S_MEM_READ;
      S_MEM_WRITE:     state_d = bus.Mem_Ready ? S_FETCH : S_MEM_WRITE;
      S_EXECUTE:       state_d = S_R_COMPLETE;
      S_ADDI_EXEC:     state_d = S_ADDI_COMPLETE;
      S_MEM_WB,
      S_R_COMPLETE,
      S_ADDI_COMPLETE,
      S_BRANCH,
      S_JUMP:          state_d = S_FETCH;
      default:         state_d = S_IDLE;
    endcase
  end

  mips_ctrl_decode u_decode (
    .state     (state_q),
    .op        (bus.Op),
    .mem_ready (bus.Mem_Ready),
    .ctrl      (ctrl)
  );

  assign bus.ALU_Op      = ctrl.alu_op;
  assign bus.ALUSrcA     = ctrl.alu_src_a;
  assign bus.ALUSrcB     = ctrl.alu_src_b;
  assign bus.PCSource    = ctrl.pc_source;
  assign bus.PCWrite     = ctrl.pc_write;
  assign bus.PCWriteCond = ctrl.pc_write_cond;
  assign bus.IorD        = ctrl.i_or_d;
  assign bus.MemRead     = ctrl.mem_read;
  assign bus.MemWrite    = ctrl.mem_write;
  assign bus.MemtoReg    = ctrl.mem_to_reg;
  assign bus.IRWrite     = ctrl.ir_write;
  assign bus.RegWrite    = ctrl.reg_write;
  assign bus.RegDst      = ctrl.reg_dst;
  assign bus.Illegal_Op  = ctrl.illegal_op;
  assign bus.State       = state_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Self-checking bench: per-instruction state paths and per-state output table vs. the DUT.
module tb_mips_multicycle_control;

  logic clk;
  logic rst_n;
  mips_multicycle_control_if bus ();

  mips_multicycle_control dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int path[$];
  int obs[$];

  // {ALU_Op, ALUSrcA, ALUSrcB, PCSource, PCWrite, PCWriteCond, IorD, MemRead,
  //  MemWrite, MemtoReg, IRWrite, RegWrite, RegDst, Illegal_Op}
  logic [16:0] act;
  assign act = {bus.ALU_Op, bus.ALUSrcA, bus.ALUSrcB, bus.PCSource, bus.PCWrite,
                bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite, bus.MemtoReg,
                bus.IRWrite, bus.RegWrite, bus.RegDst, bus.Illegal_Op};

  function automatic logic [16:0] pack(input int aluop, input int srca, input int srcb,
                                       input int pcsrc, input int pcw, input int pcwc,
                                       input int iord, input int mrd, input int mwr,
                                       input int m2r, input int irw, input int rgw,
                                       input int rdst, input int ill);
    return {2'(aluop), 1'(srca), 2'(srcb), 2'(pcsrc), 1'(pcw), 1'(pcwc), 1'(iord),
            1'(mrd), 1'(mwr), 1'(m2r), 1'(irw), 1'(rgw), 1'(rdst), 1'(ill)};
  endfunction

  // Expected controls for a state number, straight from the output table.
  function automatic logic [16:0] model_out(input int st, input bit mr, input bit ill);
    case (st)
      //            aop sa sb pcs pcw pcwc iord mrd mwr m2r irw rgw rdst ill
      1:  return pack(0, 0, 1, 0, int'(mr), 0, 0, 1, 0, 0, int'(mr), 0, 0, 0);
      2:  return pack(0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, int'(ill));
      3:  return pack(0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      4:  return pack(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
      5:  return pack(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
      6:  return pack(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0);
      7:  return pack(2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      8:  return pack(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
      9:  return pack(1, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      10: return pack(3, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      11: return pack(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      12: return pack(0, 0, 0, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      default: return '0;
    endcase
  endfunction

  function automatic bit legal(input logic [5:0] op);
    return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
  endfunction

  task automatic build_path(input logic [5:0] op);
    path.delete();
    path.push_back(1);
    path.push_back(2);
    case (op)
      6'b100011: begin path.push_back(3); path.push_back(4); path.push_back(5); end
      6'b101011: begin path.push_back(3); path.push_back(6); end
      6'b000000: begin path.push_back(7); path.push_back(8); end
      6'b000100: path.push_back(9);
      6'b001000: begin path.push_back(10); path.push_back(11); end
      6'b000010: path.push_back(12);
      default: ;
    endcase
  endtask

  task automatic check_int(input string name, input int a, input int e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, a, e, $time);
    end
  endtask

  task automatic check_vec(input string name, input logic [16:0] a, input logic [16:0] e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %05h expected %05h (t=%0t)", name, a, e, $time);
    end
  endtask

  task automatic check_str(input string name, input string a, input string e);
    n_tests++;
    if (a != e) begin
      n_fail++;
      $display("FAIL %s: got '%s' expected '%s'", name, a, e);
    end
  endtask

  function automatic string obs_str();
    string s = "";
    foreach (obs[i]) s = (i == 0) ? $sformatf("%0d", obs[i]) : $sformatf("%s,%0d", s, obs[i]);
    return s;
  endfunction

  function automatic bit is_wait(input int st);
    return st == 1 || st == 4 || st == 6;
  endfunction

  // Runs one instruction from FETCH; negative stall counts mean random.
  task automatic run_instr(input logic [5:0] op, input int fstall, input int mstall);
    int fs, ms, ms0, step, st;
    int irw, pcw, rgw, mwc;
    bit mr;
    build_path(op);
    obs.delete();
    fs  = (fstall < 0) ? int'($urandom_range(0, 3)) : fstall;
    ms  = (mstall < 0) ? int'($urandom_range(0, 3)) : mstall;
    ms0 = ms;
    irw = 0; pcw = 0; rgw = 0; mwc = 0; step = 0;
    while (step < path.size()) begin
      st = path[step];
      if (st == 1)                mr = (fs > 0) ? 1'b0 : 1'b1;
      else if (st == 4 || st == 6) mr = (ms > 0) ? 1'b0 : 1'b1;
      else                        mr = 1'($urandom_range(0, 1));
      bus.Mem_Ready = mr;
      bus.Op = (st == 2 || st == 3) ? op : 6'($urandom);
      #1;
      obs.push_back(int'(bus.State));
      check_int("state", int'(bus.State), st);
      check_vec("outputs", act, model_out(st, mr, st == 2 && !legal(op)));
      irw += int'(bus.IRWrite);
      pcw += int'(bus.PCWrite);
      rgw += int'(bus.RegWrite);
      mwc += int'(bus.MemWrite);
      @(posedge clk); #1;
      if (is_wait(st) && !mr) begin
        if (st == 1) fs--; else ms--;
      end else begin
        step++;
      end
    end
    check_int("irwrite_count", irw, 1);
    check_int("pcwrite_count", pcw, (op == 6'b000010) ? 2 : 1);
    check_int("regwrite_count", rgw,
              (op inside {6'b100011, 6'b000000, 6'b001000}) ? 1 : 0);
    check_int("memwrite_cycles", mwc, (op == 6'b101011) ? 1 + ms0 : 0);
  endtask

  task automatic step_cycle(input logic [5:0] op, input bit mr);
    bus.Op = op;
    bus.Mem_Ready = mr;
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [5:0] op;
    rst_n = 1'b0;
    bus.Op = 6'b000000;
    bus.Mem_Ready = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_int("reset_state", int'(bus.State), 0);
      check_vec("reset_outputs", act, '0);
    end
    rst_n = 1'b1;
    #1;
    check_int("idle_after_release", int'(bus.State), 0);
    check_vec("idle_outputs", act, '0);
    @(posedge clk); #1;
    check_int("fetch_after_release", int'(bus.State), 1);

    run_instr(6'b100011, 0, 0);
    check_str("lw_path", obs_str(), "1,2,3,4,5");
    run_instr(6'b000000, 0, 0);
    check_str("rtype_path", obs_str(), "1,2,7,8");
    run_instr(6'b000100, 0, 0);
    check_str("beq_path", obs_str(), "1,2,9");
    run_instr(6'b001000, 0, 0);
    check_str("addi_path", obs_str(), "1,2,10,11");
    run_instr(6'b101011, 3, 2);
    check_str("sw_stall_path", obs_str(), "1,1,1,1,2,3,6,6,6");
    run_instr(6'b000010, 0, 0);
    check_str("j_path", obs_str(), "1,2,12");
    run_instr(6'b111111, 0, 0);
    check_str("illegal_path", obs_str(), "1,2");
    check_int("back_to_fetch", int'(bus.State), 1);

    // Reset dropped during MEM_WB must kill the write-back immediately.
    step_cycle(6'b100011, 1'b1);
    step_cycle(6'b100011, 1'b1);
    step_cycle(6'b100011, 1'b1);
    step_cycle(6'b100011, 1'b1);
    check_int("mid_reset_in_memwb", int'(bus.State), 5);
    check_int("mid_reset_regwrite_before", int'(bus.RegWrite), 1);
    rst_n = 1'b0;
    #1;
    check_int("mid_reset_state", int'(bus.State), 0);
    check_int("mid_reset_regwrite_after", int'(bus.RegWrite), 0);
    check_vec("mid_reset_outputs", act, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_int("fetch_after_mid_reset", int'(bus.State), 1);

    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 6))
        0: op = 6'b100011;
        1: op = 6'b101011;
        2: op = 6'b000000;
        3: op = 6'b000100;
        4: op = 6'b001000;
        5: op = 6'b000010;
        default: begin
          op = 6'($urandom);
          while (legal(op)) op = 6'($urandom);
        end
      endcase
      run_instr(op, -1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
